// File: rtl/intr_ctrl_if.sv
// Bus between the interrupt controller and the CPU/request side.
// The master drives requests, acknowledges and mask writes; the slave reports priority state.
interface intr_ctrl_if;
   logic [7:0] irq;
   logic [7:0] s_call_intr;
   logic [7:0] s_return_intr;
   logic       mask_we;
   logic [7:0] mask_in;
   logic [7:0] min_bit_s;
   logic [7:0] min_bit_a;
   logic [2:0] intr_vec;
   logic [7:0] pending_o;
   logic [7:0] active_o;
   logic [7:0] mask_o;

   modport master (
      output irq, s_call_intr, s_return_intr, mask_we, mask_in,
      input  min_bit_s, min_bit_a, intr_vec, pending_o, active_o, mask_o
   );

   modport slave (
      input  irq, s_call_intr, s_return_intr, mask_we, mask_in,
      output min_bit_s, min_bit_a, intr_vec, pending_o, active_o, mask_o
   );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises and edge-detects 8 request lines, tracks pending
// and in-service state, and presents lowest-index (highest-priority) one-hot selections.
module intr_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          EDGE_MODE   = 1'b1,
   parameter logic [7:0]  MASK_RESET  = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   intr_ctrl_if.slave  bus
);
   localparam int unsigned N      = 8;
   localparam int unsigned WARM_W = 3;
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

   logic [N-1:0]      irq_s;
   logic [N-1:0]      irq_prev_q, irq_prev_d;
   logic [N-1:0]      req_c;
   logic [N-1:0]      pending_q, pending_d;
   logic [N-1:0]      active_q, active_d;
   logic [N-1:0]      mask_q, mask_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [N-1:0]      pend_en_c;
   logic [N-1:0]      min_s_c, min_a_c;
   logic [2:0]        vec_c;

   // Synchroniser chain; stage 0 samples the raw line, the last stage feeds detection.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign irq_s = bus.irq;
      end else begin : g_sync
         logic [SYNC_STAGES*N-1:0] sync_q, sync_d;

         always_comb begin
            sync_d      = sync_q;
            sync_d[N-1:0] = bus.irq;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
               sync_d[i*N +: N] = sync_q[(i-1)*N +: N];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) sync_q <= '0;
            else       sync_q <= sync_d;
         end

         assign irq_s = sync_q[(SYNC_STAGES-1)*N +: N];
      end
   endgenerate

   // Edge detection is held off until the synchroniser and history have refilled after
   // reset, so lines already high when reset drops are not seen as fresh edges.
   always_comb begin
      irq_prev_d = irq_s;
      warm_d     = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);
      req_c      = '0;
      if (EDGE_MODE) begin
         if (warm_q == WARM_DONE) req_c = irq_s & ~irq_prev_q;
      end else begin
         req_c = irq_s;
      end
      pending_d  = (pending_q & ~bus.s_call_intr) | req_c;
      active_d   = (active_q & ~bus.s_return_intr) | (bus.s_call_intr & pending_q);
      mask_d     = bus.mask_we ? bus.mask_in : mask_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_prev_q <= '0;
         warm_q     <= '0;
         pending_q  <= '0;
         active_q   <= '0;
         mask_q     <= MASK_RESET;
      end else begin
         irq_prev_q <= irq_prev_d;
         warm_q     <= warm_d;
         pending_q  <= pending_d;
         active_q   <= active_d;
         mask_q     <= mask_d;
      end
   end

   // Priority selection from registered state only.
   always_comb begin
      pend_en_c = pending_q & mask_q;
      min_s_c   = pend_en_c & (~pend_en_c + N'(1));
      min_a_c   = active_q & (~active_q + N'(1));
      vec_c     = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pend_en_c[i]) vec_c = 3'(i);
      end
   end

   assign bus.min_bit_s = min_s_c;
   assign bus.min_bit_a = min_a_c;
   assign bus.intr_vec  = vec_c;
   assign bus.pending_o = pending_q;
   assign bus.active_o  = active_q;
   assign bus.mask_o    = mask_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Randomised and directed bench for intr_ctrl: an edge-mode and a level-mode instance
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_intr_ctrl;
   localparam int unsigned S = 2;

   logic       clk = 1'b0;
   logic       r_reset;
   logic [7:0] r_irq, r_call, r_ret, r_mask_in;
   logic       r_mask_we;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   intr_ctrl_if bus0 ();
   intr_ctrl_if bus1 ();

   assign bus0.irq = r_irq;           assign bus1.irq = r_irq;
   assign bus0.s_call_intr = r_call;  assign bus1.s_call_intr = r_call;
   assign bus0.s_return_intr = r_ret; assign bus1.s_return_intr = r_ret;
   assign bus0.mask_we = r_mask_we;   assign bus1.mask_we = r_mask_we;
   assign bus0.mask_in = r_mask_in;   assign bus1.mask_in = r_mask_in;

   intr_ctrl #(.SYNC_STAGES(S), .EDGE_MODE(1'b1), .MASK_RESET(8'hFF)) dut_edge (
      .clk(clk), .reset(r_reset), .bus(bus0));
   intr_ctrl #(.SYNC_STAGES(S), .EDGE_MODE(1'b0), .MASK_RESET(8'hFF)) dut_level (
      .clk(clk), .reset(r_reset), .bus(bus1));

   // Behavioural model. hist[k] is the irq value seen k+1 clock edges ago.
   logic [7:0] hist [S+1];
   int         since;
   logic [7:0] m_pend [2];
   logic [7:0] m_act  [2];
   logic [7:0] m_mask [2];

   function automatic logic [7:0] sampled(input int k);
      return (k == 0) ? r_irq : hist[k-1];
   endfunction

   function automatic logic [7:0] lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return 8'(1 << i);
      return 8'h00;
   endfunction

   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
      return 3'd0;
   endfunction

   task automatic model_step();
      logic [7:0] irq_s, prev, req;
      if (r_reset) begin
         for (int k = 0; k < 2; k++) begin
            m_pend[k] = 8'h00; m_act[k] = 8'h00; m_mask[k] = 8'hFF;
         end
         for (int j = 0; j <= S; j++) hist[j] = 8'h00;
         since = 0;
      end else begin
         irq_s = sampled(S);
         prev  = sampled(S + 1);
         for (int k = 0; k < 2; k++) begin
            // Edge instance: a rising edge only counts once the pipe has refilled after reset.
            if (k == 0) req = (since > S) ? (irq_s & ~prev) : 8'h00;
            else        req = irq_s;
            m_act[k]  = (m_act[k] & ~r_ret) | (r_call & m_pend[k]);
            m_pend[k] = (m_pend[k] & ~r_call) | req;
            if (r_mask_we) m_mask[k] = r_mask_in;
         end
         if (since < 1000) since++;
         for (int j = S; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = r_irq;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      started = 1'b1;
      #1;
   endtask

   task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic [42:0] got, exp;
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            if (k == 0) got = {bus0.pending_o, bus0.active_o, bus0.mask_o,
                               bus0.min_bit_s, bus0.min_bit_a, bus0.intr_vec};
            else        got = {bus1.pending_o, bus1.active_o, bus1.mask_o,
                               bus1.min_bit_s, bus1.min_bit_a, bus1.intr_vec};
            exp = {m_pend[k], m_act[k], m_mask[k], lowest(m_pend[k] & m_mask[k]),
                   lowest(m_act[k]), lowest_idx(m_pend[k] & m_mask[k])};
            n_tests++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL model_inst%0d t=%0t got %h expected %h (p,a,m,s,sa,vec)",
                        k, $time, got, exp);
            end
         end
      end
   end

   task automatic drain();
      r_irq = 8'h00;
      repeat (S + 2) cyc();
      for (int i = 0; i < 8; i++) begin
         r_call = 8'(1 << i); cyc(); r_call = 8'h00;
         r_ret  = 8'(1 << i); cyc(); r_ret  = 8'h00;
      end
   endtask

   task automatic pulse(input logic [7:0] v);
      r_irq = v; cyc(); r_irq = 8'h00; cyc(); cyc();
   endtask

   initial begin
      r_reset = 1'b1; r_irq = 8'hFF; r_call = 8'h00; r_ret = 8'h00;
      r_mask_we = 1'b0; r_mask_in = 8'h00;

      // Reset with all lines high
      repeat (3) cyc();
      lit("rst_pending", bus0.pending_o, 8'h00);
      lit("rst_active",  bus0.active_o,  8'h00);
      lit("rst_mask",    bus0.mask_o,    8'hFF);
      lit("rst_min_s",   bus0.min_bit_s, 8'h00);
      r_reset = 1'b0;
      repeat (5) cyc();
      lit("rel_no_edge", bus0.pending_o, 8'h00);
      drain();

      // Single edge on irq[3]
      r_irq = 8'h08;
      cyc(); cyc();
      lit("edge_e1_pend", bus0.pending_o, 8'h00);
      cyc();
      lit("edge_e2_pend", bus0.pending_o, 8'h08);
      lit("edge_min_s",   bus0.min_bit_s, 8'h08);
      lit("edge_vec",     {5'd0, bus0.intr_vec}, 8'h03);
      r_call = 8'h08; cyc(); r_call = 8'h00;
      lit("call_pend",  bus0.pending_o, 8'h00);
      lit("call_act",   bus0.active_o,  8'h08);
      lit("call_min_a", bus0.min_bit_a, 8'h08);

      // Priority and nesting
      pulse(8'h20);
      lit("nest_min_s5", bus0.min_bit_s, 8'h20);
      lit("nest_act",    bus0.active_o,  8'h08);
      pulse(8'h02);
      lit("nest_min_s1", bus0.min_bit_s, 8'h02);
      r_call = 8'h02; cyc(); r_call = 8'h00;
      lit("nest_act2",   bus0.active_o,  8'h0A);
      lit("nest_min_a",  bus0.min_bit_a, 8'h02);
      r_ret = 8'h02; cyc(); r_ret = 8'h00;
      lit("nest_ret",    bus0.active_o,  8'h08);

      // New edge on irq[2] in the same cycle as its call
      r_irq = 8'h04; cyc(); r_irq = 8'h00; cyc();
      r_irq = 8'h04; cyc(); r_irq = 8'h00; cyc();
      r_call = 8'h04; cyc(); r_call = 8'h00;
      lit("simul_pend", bus0.pending_o & 8'h04, 8'h04);
      lit("simul_act",  bus0.active_o  & 8'h04, 8'h04);
      drain();

      // Mask
      r_mask_we = 1'b1; r_mask_in = 8'hFE; cyc(); r_mask_we = 1'b0;
      pulse(8'h01);
      lit("mask_pend",  bus0.pending_o, 8'h01);
      lit("mask_min_s", bus0.min_bit_s, 8'h00);
      r_mask_we = 1'b1; r_mask_in = 8'hFF; cyc(); r_mask_we = 1'b0;
      lit("unmask_min_s", bus0.min_bit_s, 8'h01);
      drain();

      // Level mode on the second instance
      r_irq = 8'h10;
      repeat (3) cyc();
      r_call = 8'h10; cyc(); r_call = 8'h00;
      lit("lvl_pend",  bus1.pending_o, 8'h10);
      lit("lvl_min_s", bus1.min_bit_s, 8'h10);
      lit("lvl_min_a", bus1.min_bit_a, 8'h10);
      r_irq = 8'h00; r_ret = 8'h10; cyc(); r_ret = 8'h00;
      lit("lvl_ret_act", bus1.active_o, 8'h00);
      cyc(); cyc();
      r_call = 8'h10; cyc(); r_call = 8'h00;
      lit("lvl_clear_pend", bus1.pending_o, 8'h00);
      r_ret = 8'h10; cyc(); r_ret = 8'h00;

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r_irq = r_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) r_call = bus0.min_bit_s;
            else                           r_call = 8'(1 << $urandom_range(0, 7));
         end else r_call = 8'h00;
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) r_ret = bus0.min_bit_a;
            else                           r_ret = 8'(1 << $urandom_range(0, 7));
         end else r_ret = 8'h00;
         r_mask_we = ($urandom_range(0, 15) == 0);
         r_mask_in = 8'($urandom);
         r_reset   = ($urandom_range(0, 399) == 0);
         cyc();
      end
      r_reset = 1'b0; r_call = 8'h00; r_ret = 8'h00; r_mask_we = 1'b0;
      cyc(); cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
